ysyx_23060059_wbu_sb: RTL and testbench
=======================================

# ysyx_23060059_wbu_sb

Parametrised write-back unit for the pipelined NPC core: holds the GPR and CSR files, accepts one retiring instruction per cycle over a valid/ready handshake, and keeps a per-GPR scoreboard so the issue stage can detect RAW/WAW hazards. It sits at the end of EXU/LSU and feeds read data and busy flags back to IDU, plus a registered commit record for difftest and the halt logic.

## Interface
- XLEN, 32: data width of GPRs, CSRs and PCs.
- NR_GPR, 32: GPR count (16 for RV32E); AW = $clog2(NR_GPR).
- NR_CSR, 4: CSR slots (0 mcause, 1 mepc, 2 mstatus, 3 mtvec); CW = $clog2(NR_CSR).
- NREAD, 2: GPR read ports.
- ECALL_SRC, 15: GPR copied into mcause on ecall (a5).
- CNT_W, 64: retire counter width.

Clock and reset: `clock` and `reset`, one clock, synchronous active-high reset.

- clock  in  1  core clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  retiring instruction present
- in_ready  out  1  unit accepts; 0 once halted
- in_rd  in  AW  GPR destination
- in_wd  in  XLEN  GPR write data
- in_reg_en  in  1  GPR write enable
- in_csr_rd  in  CW  CSR destination
- in_csr_wd  in  XLEN  CSR write data
- in_csr_en  in  1  CSR write enable
- in_ecall  in  1  ecall retiring
- in_ebreak  in  1  ebreak retiring
- in_pc, in_pc_next, in_inst  in  XLEN each  commit info
- iss_valid  in  1  IDU marks a destination busy
- iss_rd  in  AW  register being issued
- iss_ready  out  1  issue allowed (no WAW)
- rs_addr  in  NREAD*AW  packed read addresses
- rs_data  out  NREAD*XLEN  packed read data
- rs_busy  out  NREAD  packed busy flags
- csr_rs  in  CW  CSR read address
- csr_data  out  XLEN  CSR read data
- commit_valid  out  1  one-cycle pulse per accepted instruction
- commit_pc, commit_pc_next, commit_inst  out  XLEN each  registered commit record
- retire_cnt  out  CNT_W  accepted-instruction count
- halted  out  1  sticky ebreak flag

## Operation
- Accept = in_valid & in_ready; in_ready = !halted.
- On accept: GPR[in_rd] <= in_wd if in_reg_en and in_rd != 0; CSR[in_csr_rd] <= in_csr_wd if in_csr_en.
- ecall on accept: mcause <= GPR[ECALL_SRC] (pre-write value); overrides a same-cycle CSR write to slot 0. Other CSR writes proceed.
- ebreak on accept: halted <= 1; the ebreak itself commits normally.
- GPR0 reads 0, never busy, never written.
- Scoreboard busy[NR_GPR]: set on iss_valid & iss_ready & iss_rd != 0; cleared on accept with in_reg_en for in_rd.
- iss_ready = !busy[iss_rd] | (accept & in_reg_en & in_rd == iss_rd) | iss_rd == 0.
- Same-cycle set and clear of one register: set wins (busy stays 1).
- Without accept nothing changes except scoreboard sets.
- Read ports are combinational from the register array; CSR read likewise.

## Timing
- Write and scoreboard clear visible from cycle after accept.
- commit_valid, commit_pc/pc_next/inst registered: high exactly one cycle after accept; retire_cnt increments at the same edge, wraps modulo 2^CNT_W.
- Reset: all GPRs, CSRs, busy bits, commit fields, retire_cnt, halted = 0; commit_valid = 0; in_ready = 1.
- Reset mid-operation discards the in-flight accept and all pending busy bits.
- Halted: in_valid ignored, no writes or counter changes; scoreboard sets continue.

## Configuration
- YSYX_23060059_WBU_BYPASS_EN defined: rs_data returns in_wd and rs_busy = 0 when accept & in_reg_en & rs_addr == in_rd != 0 (same-cycle forward).
- Undefined: rs_data is the array value; rs_busy stays 1 until the cycle after the write.

## Structure
- Shared package ysyx_23060059_pkg: CSR index constants (CSR_MCAUSE=0, CSR_MEPC=1, CSR_MSTATUS=2, CSR_MTVEC=3), default XLEN, commit record struct.
- One sub-module ysyx_23060059_scoreboard (busy bits, iss_ready, set/clear priority); register arrays and commit logic in the top.

## Test plan
- Reset, read x1..x31 -> 0, rs_busy 0, in_ready 1, retire_cnt 0.
- Issue x5, retire rd=5 wd=0xDEADBEEF -> rs_busy[0] 1 until write; next cycle rs_data 0xDEADBEEF, busy 0, commit_valid pulse, retire_cnt 1.
- Write rd=0 wd=0x1234 -> x0 reads 0; issue x0 -> iss_ready 1, never busy.
- Issue x7 twice -> second iss_ready 0; same cycle as retire of x7 -> iss_ready 1, busy stays 1.
- x15=0xB, retire ecall plus csr_en slot 0 wd=0x99 -> mcause 0xB.
- Retire ebreak -> halted 1, in_ready 0; further in_valid ignored, retire_cnt frozen. Bypass build: read x3 during its retire -> in_wd same cycle.

Source files
------------

// File: rtl/ysyx_23060059_pkg.sv
// ysyx_23060059_pkg: shared constants and types for the NPC write-back path
package ysyx_23060059_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        CSR_MCAUSE  = 2'd0,
        CSR_MEPC    = 2'd1,
        CSR_MSTATUS = 2'd2,
        CSR_MTVEC   = 2'd3
    } csr_idx_e;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] pc_next;
        logic [XLEN_DEFAULT-1:0] inst;
    } commit_t;

endpackage

// File: rtl/ysyx_23060059_wbu_sb_if.sv
// ysyx_23060059_wbu_sb_if: retire handshake from EXU/LSU into the write-back unit
interface ysyx_23060059_wbu_sb_if
    import ysyx_23060059_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int AW   = 5,
    parameter int CW   = 2
);
    logic            valid;
    logic            ready;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] wd;
    logic            reg_en;
    logic [CW-1:0]   csr_rd;
    logic [XLEN-1:0] csr_wd;
    logic            csr_en;
    logic            ecall;
    logic            ebreak;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] inst;

    modport master (
        output valid, rd, wd, reg_en, csr_rd, csr_wd, csr_en, ecall, ebreak, pc, pc_next, inst,
        input  ready
    );

    modport slave (
        input  valid, rd, wd, reg_en, csr_rd, csr_wd, csr_en, ecall, ebreak, pc, pc_next, inst,
        output ready
    );
endinterface

// File: rtl/ysyx_23060059_wbu_sb_scoreboard.sv
// ysyx_23060059_scoreboard: per-GPR busy bits for RAW/WAW detection at issue
// Optional YSYX_23060059_WBU_BYPASS_EN hides busy for a register retiring this cycle.
module ysyx_23060059_scoreboard #(
    parameter  int NR_GPR = 32,
    parameter  int NREAD  = 2,
    localparam int AW     = $clog2(NR_GPR)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ready,
    input  logic                clr_en,
    input  logic [AW-1:0]       clr_rd,
    input  logic [NREAD*AW-1:0] rs_addr,
    output logic [NREAD-1:0]    rs_busy
);
    logic [NR_GPR-1:0] busy;

    assign iss_ready = !busy[iss_rd] || (clr_en && clr_rd == iss_rd) || iss_rd == '0;

    // A set in the same cycle as a clear wins: the new producer owns the register.
    always_ff @(posedge clock) begin
        if (reset)
            busy <= '0;
        else
            for (int i = 0; i < NR_GPR; i++)
                busy[i] <= i != 0 && ((iss_valid && iss_ready && iss_rd == AW'(i)) ||
                                      (busy[i] && !(clr_en && clr_rd == AW'(i))));
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_busy
        logic [AW-1:0] a;
        assign a = rs_addr[k*AW +: AW];
`ifdef YSYX_23060059_WBU_BYPASS_EN
        assign rs_busy[k] = busy[a] && !(clr_en && clr_rd == a);
`else
        assign rs_busy[k] = busy[a];
`endif
    end
endmodule

// File: rtl/ysyx_23060059_wbu_sb.sv
// ysyx_23060059_wbu_sb: write-back unit with GPR/CSR files, scoreboard and commit record
// Optional YSYX_23060059_WBU_BYPASS_EN forwards the retiring write to the read ports.
module ysyx_23060059_wbu_sb
    import ysyx_23060059_pkg::*;
#(
    parameter  int XLEN      = XLEN_DEFAULT,
    parameter  int NR_GPR    = 32,
    parameter  int NR_CSR    = 4,
    parameter  int NREAD     = 2,
    parameter  int ECALL_SRC = 15,
    parameter  int CNT_W     = 64,
    localparam int AW        = $clog2(NR_GPR),
    localparam int CW        = $clog2(NR_CSR)
) (
    input  logic                  clock,
    input  logic                  reset,
    ysyx_23060059_wbu_sb_if.slave in_bus,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    output logic                  iss_ready,
    input  logic [NREAD*AW-1:0]   rs_addr,
    output logic [NREAD*XLEN-1:0] rs_data,
    output logic [NREAD-1:0]      rs_busy,
    input  logic [CW-1:0]         csr_rs,
    output logic [XLEN-1:0]       csr_data,
    output logic                  commit_valid,
    output logic [XLEN-1:0]       commit_pc,
    output logic [XLEN-1:0]       commit_pc_next,
    output logic [XLEN-1:0]       commit_inst,
    output logic [CNT_W-1:0]      retire_cnt,
    output logic                  halted
);
    logic [XLEN-1:0] gpr [NR_GPR];
    logic [XLEN-1:0] csr [NR_CSR];
    logic            acc;
    logic            wr_en;

    assign in_bus.ready = !halted;
    assign acc          = in_bus.valid && in_bus.ready;
    assign wr_en        = acc && in_bus.reg_en && in_bus.rd != '0;
    assign csr_data     = csr[csr_rs];

    ysyx_23060059_scoreboard #(.NR_GPR(NR_GPR), .NREAD(NREAD)) u_sb (
        .clock     (clock),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .clr_en    (acc && in_bus.reg_en),
        .clr_rd    (in_bus.rd),
        .rs_addr   (rs_addr),
        .rs_busy   (rs_busy)
    );

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rs_addr[k*AW +: AW];
`ifdef YSYX_23060059_WBU_BYPASS_EN
        assign rs_data[k*XLEN +: XLEN] = (wr_en && in_bus.rd == a) ? in_bus.wd : gpr[a];
`else
        assign rs_data[k*XLEN +: XLEN] = gpr[a];
`endif
    end

    // gpr[0] is only ever written by reset, so it always reads zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NR_GPR; i++) gpr[i] <= '0;
            for (int i = 0; i < NR_CSR; i++) csr[i] <= '0;
            commit_valid   <= 1'b0;
            commit_pc      <= '0;
            commit_pc_next <= '0;
            commit_inst    <= '0;
            retire_cnt     <= '0;
            halted         <= 1'b0;
        end else begin
            commit_valid <= acc;
            if (wr_en) gpr[in_bus.rd] <= in_bus.wd;
            if (acc) begin
                if (in_bus.csr_en) csr[in_bus.csr_rd] <= in_bus.csr_wd;
                if (in_bus.ecall) csr[CSR_MCAUSE] <= gpr[ECALL_SRC];
                if (in_bus.ebreak) halted <= 1'b1;
                commit_pc      <= in_bus.pc;
                commit_pc_next <= in_bus.pc_next;
                commit_inst    <= in_bus.inst;
                retire_cnt     <= retire_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_ysyx_23060059_wbu_sb.sv
// tb_ysyx_23060059_wbu_sb: randomized scoreboard bench for the write-back unit
module tb_ysyx_23060059_wbu_sb;
    import ysyx_23060059_pkg::*;

    localparam int XLEN = 32, NR_GPR = 32, NR_CSR = 4, NREAD = 2, ECALL_SRC = 15, CNT_W = 64;
    localparam int AW = 5, CW = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ysyx_23060059_wbu_sb_if #(.XLEN(XLEN), .AW(AW), .CW(CW)) bus ();

    logic                  iss_valid;
    logic [AW-1:0]         iss_rd;
    logic                  iss_ready;
    logic [NREAD*AW-1:0]   rs_addr;
    logic [NREAD*XLEN-1:0] rs_data;
    logic [NREAD-1:0]      rs_busy;
    logic [CW-1:0]         csr_rs;
    logic [XLEN-1:0]       csr_data;
    logic                  commit_valid;
    logic [XLEN-1:0]       commit_pc, commit_pc_next, commit_inst;
    logic [CNT_W-1:0]      retire_cnt;
    logic                  halted;

    ysyx_23060059_wbu_sb #(
        .XLEN(XLEN), .NR_GPR(NR_GPR), .NR_CSR(NR_CSR), .NREAD(NREAD),
        .ECALL_SRC(ECALL_SRC), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .in_bus(bus),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
        .csr_rs(csr_rs), .csr_data(csr_data),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_pc_next(commit_pc_next),
        .commit_inst(commit_inst), .retire_cnt(retire_cnt), .halted(halted)
    );

    int errors = 0, checks = 0;

    logic [XLEN-1:0] m_gpr [NR_GPR];
    logic [XLEN-1:0] m_csr [NR_CSR];
    bit              m_busy [NR_GPR];
    bit              m_halted;
    logic [63:0]     m_cnt;

    typedef struct packed {
        commit_t     rec;
        logic [63:0] cnt;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR_GPR; i++) begin m_gpr[i] = '0; m_busy[i] = 0; end
        for (int i = 0; i < NR_CSR; i++) m_csr[i] = '0;
        m_halted = 0;
        m_cnt = '0;
        q.delete();
    endtask

    task automatic idle();
        bus.valid = 0; bus.rd = '0; bus.wd = '0; bus.reg_en = 0;
        bus.csr_rd = '0; bus.csr_wd = '0; bus.csr_en = 0; bus.ecall = 0; bus.ebreak = 0;
        bus.pc = '0; bus.pc_next = '0; bus.inst = '0;
        iss_valid = 0; iss_rd = '0; rs_addr = '0; csr_rs = '0;
    endtask

    function automatic logic [AW-1:0] pick_reg();
        return ($urandom_range(0, 9) == 0) ? AW'(ECALL_SRC) : AW'($urandom_range(0, 7));
    endfunction

    task automatic rand_inputs(input bit allow_ebreak);
        bus.valid   = $urandom_range(0, 9) < 7;
        bus.rd      = pick_reg();
        bus.wd      = $urandom;
        bus.reg_en  = $urandom_range(0, 3) != 0;
        bus.csr_rd  = CW'($urandom_range(0, NR_CSR - 1));
        bus.csr_wd  = $urandom;
        bus.csr_en  = $urandom_range(0, 3) == 0;
        bus.ecall   = $urandom_range(0, 7) == 0;
        bus.ebreak  = allow_ebreak && $urandom_range(0, 3) == 0;
        bus.pc      = $urandom;
        bus.pc_next = $urandom;
        bus.inst    = $urandom;
        iss_valid   = $urandom_range(0, 1) == 1;
        iss_rd      = pick_reg();
        rs_addr     = {pick_reg(), pick_reg()};
        csr_rs      = CW'($urandom_range(0, NR_CSR - 1));
    endtask

    // Check combinational outputs against the model, then apply the spec's retire rules at the edge.
    task automatic step();
        logic            acc, exp_iss;
        logic [AW-1:0]   a;
        logic [XLEN-1:0] mc;
        exp_t            e;
        #1;
        acc     = bus.valid && !m_halted;
        exp_iss = !m_busy[iss_rd] || (acc && bus.reg_en && bus.rd == iss_rd) || iss_rd == '0;
        chk("in_ready", 64'(bus.ready), 64'(!m_halted));
        chk("halted", 64'(halted), 64'(m_halted));
        chk("retire_cnt", retire_cnt, m_cnt);
        chk("csr_data", 64'(csr_data), 64'(m_csr[csr_rs]));
        chk("iss_ready", 64'(iss_ready), 64'(exp_iss));
        for (int k = 0; k < NREAD; k++) begin
            a = rs_addr[k*AW +: AW];
`ifdef YSYX_23060059_WBU_BYPASS_EN
            begin
                logic fwd;
                fwd = acc && bus.reg_en && bus.rd == a && a != '0;
                chk("rs_data", 64'(rs_data[k*XLEN +: XLEN]), 64'(fwd ? bus.wd : m_gpr[a]));
                chk("rs_busy", 64'(rs_busy[k]), 64'(m_busy[a] && !fwd));
            end
`else
            chk("rs_data", 64'(rs_data[k*XLEN +: XLEN]), 64'(m_gpr[a]));
            chk("rs_busy", 64'(rs_busy[k]), 64'(m_busy[a]));
`endif
        end
        @(posedge clock);
        if (acc) begin
            mc = m_gpr[ECALL_SRC];
            if (bus.reg_en && bus.rd != '0) m_gpr[bus.rd] = bus.wd;
            if (bus.csr_en) m_csr[bus.csr_rd] = bus.csr_wd;
            if (bus.ecall) m_csr[0] = mc;
            if (bus.ebreak) m_halted = 1;
            m_cnt = m_cnt + 1;
            e.rec.pc = bus.pc; e.rec.pc_next = bus.pc_next; e.rec.inst = bus.inst; e.cnt = m_cnt;
            q.push_back(e);
            if (bus.reg_en) m_busy[bus.rd] = 0;
        end
        if (iss_valid && exp_iss && iss_rd != '0) m_busy[iss_rd] = 1;
        @(negedge clock);
    endtask

    task automatic do_reset(input bit busy_inputs);
        if (!busy_inputs) idle();
        reset = 1;
        @(posedge clock);
        @(negedge clock);
        reset = 0;
        idle();
        model_clear();
        #1;
        chk("rst_commit_valid", 64'(commit_valid), 64'(0));
        chk("rst_commit_pc", 64'(commit_pc), 64'(0));
        chk("rst_retire_cnt", retire_cnt, 64'(0));
        chk("rst_halted", 64'(halted), 64'(0));
    endtask

    task automatic retire(input int rd, input logic [XLEN-1:0] wd);
        bus.valid = 1; bus.rd = AW'(rd); bus.wd = wd; bus.reg_en = 1;
        bus.pc = $urandom; bus.pc_next = $urandom; bus.inst = $urandom;
    endtask

    // Commit monitor: every pulse must match the oldest accepted instruction.
    always @(posedge clock) begin
        #1;
        if (commit_valid === 1'b1 && !reset) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL commit_unexpected: got commit_valid=1, expected 0 at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("commit_pc", 64'(commit_pc), 64'(e.rec.pc));
                chk("commit_pc_next", 64'(commit_pc_next), 64'(e.rec.pc_next));
                chk("commit_inst", 64'(commit_inst), 64'(e.rec.inst));
                chk("commit_cnt", retire_cnt, e.cnt);
            end
        end
    end

    initial begin
        idle();
        reset = 1;
        @(posedge clock);
        @(negedge clock);
        do_reset(0);
        for (int r = 1; r < NR_GPR; r++) begin
            rs_addr = {AW'(r), AW'(r)};
            step();
        end
        idle(); iss_valid = 1; iss_rd = 5; step();
        idle(); rs_addr = {AW'(0), AW'(5)}; step();
        retire(5, 32'hDEADBEEF); rs_addr = {AW'(0), AW'(5)}; step();
        idle(); rs_addr = {AW'(0), AW'(5)}; step();
        retire(0, 32'h1234); step();
        idle(); iss_valid = 1; iss_rd = 0; step();
        idle(); step();
        idle(); iss_valid = 1; iss_rd = 7; step();
        step();
        retire(7, 32'h77); iss_valid = 1; iss_rd = 7; step();
        idle(); rs_addr = {AW'(7), AW'(7)}; step();
        retire(7, 32'h78); step();
        idle(); rs_addr = {AW'(7), AW'(7)}; step();
        retire(15, 32'hB); step();
        idle(); bus.valid = 1; bus.ecall = 1; bus.csr_en = 1; bus.csr_rd = 0; bus.csr_wd = 32'h99; step();
        idle(); csr_rs = 0; step();
        retire(3, 32'h3333); rs_addr = {AW'(3), AW'(3)}; step();
        for (int n = 0; n < 1500; n++) begin
            rand_inputs(0);
            step();
        end
        for (int n = 0; n < 10; n++) begin
            idle(); iss_valid = 1; iss_rd = AW'(n + 1); step();
        end
        rand_inputs(0);
        do_reset(1);
        for (int r = 0; r < NR_GPR; r += 2) begin
            rs_addr = {AW'(r), AW'(r + 1)};
            csr_rs = CW'(r % NR_CSR);
            step();
        end
        for (int n = 0; n < 200; n++) begin
            rand_inputs(0);
            step();
        end
        idle(); bus.valid = 1; bus.ebreak = 1; step();
        for (int n = 0; n < 40; n++) begin
            rand_inputs(1);
            bus.valid = 1;
            step();
        end
        idle();
        repeat (3) @(negedge clock);
        chk("commit_queue_empty", 64'(q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
